// File: rtl/rca_ctrl_pkg.sv
// Shared constants for the nibble-serial adder sequencer: state encoding,
// slice width and the nibble-counter width helper.
package rca_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A single-nibble sequencer still needs a one-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder; exposes the carry out of every bit position so
// callers can derive both unsigned carry and signed overflow.
module ripple_carry_adder
  import rca_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic [NIBBLE_W-1:0] co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE_W:1];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide adder built from one shared 4-bit ripple-carry adder, one nibble per
// clock LSB first. Define RCA_SIGNED_OVF_EN to add the signed-overflow output ovf.
module rca_seq_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
`ifdef RCA_SIGNED_OVF_EN
  output logic                          ovf,
`endif
  output logic                          busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [W-1:0]        a_sr;
  logic [W-1:0]        b_sr;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic [NIBBLE_W-1:0] add_s;
  logic [NIBBLE_W-1:0] add_co;
  logic                accept;
  logic                last;

  assign accept = in_valid && in_ready;
  assign last   = (state == ST_RUN) && (cnt == CNT_LAST);

  ripple_carry_adder u_rca (
    .a  (a_sr[NIBBLE_W-1:0]),
    .b  (b_sr[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  // out_valid is registered from the next state so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_RUN) || (state == ST_DONE);
  end

  // Each nibble result enters at the top of sum so after NIBBLES shifts it is aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> NIBBLE_W;
      b_sr  <= b_sr >> NIBBLE_W;
      sum   <= (sum >> NIBBLE_W) | (W'(add_s) << (W - NIBBLE_W));
      carry <= add_co[NIBBLE_W-1];
      cnt   <= cnt + 1'b1;
      if (last) cout <= add_co[NIBBLE_W-1];
    end
  end

`ifdef RCA_SIGNED_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= add_co[NIBBLE_W-1] ^ add_co[NIBBLE_W-2];
  end

  logic [NIBBLE_W-3:0] unused_co;
  assign unused_co = add_co[NIBBLE_W-3:0];
`else
  logic [NIBBLE_W-2:0] unused_co;
  assign unused_co = add_co[NIBBLE_W-2:0];
`endif

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: a transaction-level model checked every cycle on a
// 4-nibble instance, plus directed checks and a 1-nibble instance.
module tb_rca_seq_ctrl;

  localparam int N0 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sum;
`ifdef RCA_SIGNED_OVF_EN
  logic        ovf;
`endif

  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, cout1, busy1;
  logic [3:0]  sum1;
`ifdef RCA_SIGNED_OVF_EN
  logic        ovf1;
`endif

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.NIBBLES(N0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef RCA_SIGNED_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  rca_seq_ctrl #(.NIBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1),
`ifdef RCA_SIGNED_OVF_EN
    .ovf(ovf1),
`endif
    .busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op is answered with the full-width sum
  // after N0 further edges, then held until the consumer takes it.
  logic        m_idle = 1'b1, m_valid = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_sum = '0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_valid = 1'b0; m_left = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        {m_cout, m_sum} = 17'(a) + 17'(b) + 17'(cin);
        m_ovf  = (a[15] == b[15]) && (m_sum[15] != a[15]);
        m_left = N0;
        m_idle = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc in_ready", in_ready, m_idle);
      chk("cyc busy", busy, !m_idle);
      chk("cyc out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("cyc sum", sum, m_sum);
        chk("cyc cout", cout, m_cout);
`ifdef RCA_SIGNED_OVF_EN
        chk("cyc ovf", ovf, m_ovf);
`endif
      end
    end
  end

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    @(posedge clk); #2;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_out(output int lat);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    chk("in_ready after take", in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst sum", sum, 16'h0000);
    chk("rst cout", cout, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst1 in_ready", in_ready1, 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: trivial add, latency
    start_op(16'h0001, 16'h0000, 1'b0);
    wait_out(lat);
    chk("t1 latency", lat, N0 + 1);
    chk("t1 sum", sum, 16'h0001);
    chk("t1 cout", cout, 1'b0);
    release_out();

    // 2: carry through every nibble
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t2 sum", sum, 16'h0000);
    chk("t2 cout", cout, 1'b1);
    release_out();

    // 3: backpressure with ignored operands
    start_op(16'h2B5A, 16'h64C3, 1'b1);
    wait_out(lat);
    chk("t3 latency", lat, N0 + 1);
    chk("t3 sum", sum, 16'h901E);
    chk("t3 cout", cout, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      in_valid = (i % 2 == 0); a = 16'h1111 * 16'(i + 1); b = 16'h0F0F; cin = 1'b1;
      #1;
      chk("t3 hold sum", sum, 16'h901E);
      chk("t3 hold valid", out_valid, 1'b1);
      chk("t3 hold in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    release_out();

    // 4: reset in the second RUN cycle
    start_op(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t4 rst out_valid", out_valid, 1'b0);
    chk("t4 rst sum", sum, 16'h0000);
    chk("t4 rst cout", cout, 1'b0);
    chk("t4 rst busy", busy, 1'b0);
    chk("t4 rst in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < N0 + 3; i++) begin
      @(posedge clk); #1;
      chk("t4 no out_valid", out_valid, 1'b0);
    end
    start_op(16'h0005, 16'h0003, 1'b0);
    wait_out(lat);
    chk("t4 sum", sum, 16'h0008);
    chk("t4 cout", cout, 1'b0);
    release_out();

`ifdef RCA_SIGNED_OVF_EN
    // 5: signed overflow flag
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t5a sum", sum, 16'h8000);
    chk("t5a ovf", ovf, 1'b1);
    chk("t5a cout", cout, 1'b0);
    release_out();
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t5b ovf", ovf, 1'b0);
    chk("t5b cout", cout, 1'b1);
    release_out();
`endif

    // 6: single-nibble instance
    @(posedge clk); #2;
    a1 = 4'hB; b1 = 4'h6; cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #2;
    in_valid1 = 1'b0; a1 = '0; b1 = '0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid1) break;
    end
    chk("t6 latency", lat, 2);
    chk("t6 sum", sum1, 4'h1);
    chk("t6 cout", cout1, 1'b1);
    chk("t6 busy", busy1, 1'b1);
    @(posedge clk); #2 out_ready1 = 1'b1;
    @(posedge clk); #2 out_ready1 = 1'b0;
    chk("t6 in_ready after take", in_ready1, 1'b1);
    chk("t6 out_valid after take", out_valid1, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
